adder_accum_ctrl: RTL
=====================

# adder_accum_ctrl

Sequential accumulator controller that sits directly upstream and downstream of the team's 16-bit flag-generating adder. It drives the adder's X and Y operand inputs and consumes its sum and flags (sign, zero, carry, overflow, parity). It sums a burst of `len` operands arriving on a valid/ready stream and presents the final sum with registered flags on an output valid/ready port. Throughput is one operand per cycle.

## Interface
- `WIDTH`, 16, datapath width; must match the adder.
- `CNT_W`, 8, width of the burst-length counter.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  CNT_W  operand count for the burst, sampled with `start`.
- `in_valid`  in  1  operand valid.
- `in_data`  in  WIDTH  operand.
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`.
- `add_x`  out  WIDTH  to adder X; always equals the accumulator register.
- `add_y`  out  WIDTH  to adder Y; combinationally equals `in_data`.
- `add_z`  in  WIDTH  adder sum.
- `add_sign`, `add_zero`, `add_carry`, `add_overflow`, `add_parity`  in  1 each  adder flags.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_sum`  out  WIDTH  accumulated sum.
- `out_flags`  out  5  {sign, zero, carry, overflow, parity}, registered.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ACCUM, DONE.
- **IDLE**
  - `start` with `len==0`: go to DONE. Sum is 0x0000; flags are zero=1, parity=1, all others 0.
  - `start` with `len>0`: clear the accumulator and flags, load count=`len`, go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On each handshake: accumulator <= `add_z`, flags captured from the adder, count decrements.
  - A handshake with count==1 goes to DONE.
  - `in_valid` low stalls the burst; state is held.
- **DONE**
  - `out_valid`=1. `out_sum` and `out_flags` hold stable until the output handshake.
  - Handshake returns to IDLE.
- `start` outside IDLE is ignored. `in_ready`=0 outside ACCUM.
- **Arithmetic:** modulo 2^WIDTH. Adder carry-out is dropped from the sum and appears only in the carry flag.
- **Reset:** asynchronous at any point, including mid-burst.
  - State returns to IDLE; accumulator, count and flags clear.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `out_sum`=0, `out_flags`=0.
  - Any partial burst is discarded.

## Timing
- The adder path is combinational within one cycle: `add_x`/`add_y` to `add_z`.
- Latency: `out_valid` rises on the first edge after the final operand handshake.
- `len==0`: `out_valid` rises on the first edge after `start`.
- Back-to-back operands: one per cycle, no bubbles.
- A new `start` is accepted at the earliest in the cycle after the DONE to IDLE transition.

## Configuration
- `STICKY_FLAGS_EN` defined:
  - Carry and overflow accumulate by sticky OR across all operands of the burst.
  - Sign, zero and parity come from the last add.
- `STICKY_FLAGS_EN` undefined: all five flags come from the last add only.

## Structure
- **Shared package:**
  - state encoding (IDLE/ACCUM/DONE);
  - flag bit-index constants (SIGN=4, ZERO=3, CARRY=2, OVF=1, PAR=0);
  - default `WIDTH`.
- **Sub-module:** one natural sub-module, `acc_flag_reg`, containing the flag capture register and the sticky-merge logic under the macro.
- The adder itself is instantiated outside this block, by the parent.

## Test plan
- **Simple sum:** `len`=3, operands 0x0001, 0x0002, 0x0003 -> `out_sum`=0x0006, flags=0b00001 (parity=1).
- **Signed overflow:** `len`=2, operands 0x7FFF, 0x0001 -> `out_sum`=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0.
- **Sticky carry:** `len`=3, operands 0xFFFF, 0x0001, 0x0005 -> `out_sum`=0x0005.
  - Carry=1 with `STICKY_FLAGS_EN`.
  - Carry=0 without it.
- **Empty burst and backpressure:** `len`=0 -> `out_valid` the next cycle with sum 0x0000 and flags 0b01001. Hold `out_ready`=0 for 5 cycles -> outputs stable; `start` pulses during DONE are ignored.
- **Stalls:** `len`=4 with `in_valid` gaps of 2 cycles between operands -> correct sum, and the count decrements only on handshakes.
- **Reset mid-burst:** assert `rst` after 2 of 4 operands -> immediate IDLE with all outputs 0. A following burst of `len`=1 with operand 0x1234 -> `out_sum`=0x1234.

Source files
------------

// File: rtl/adder_accum_ctrl_pkg.sv
// Shared definitions for the adder accumulator controller: FSM encoding,
// flag bit positions and default widths.
package adder_accum_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 8;
  localparam int NFLAGS        = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int FLAG_SIGN  = 4;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_PAR   = 0;

  // Flags describing a sum of 0x0000: zero set, even parity set.
  function automatic logic [NFLAGS-1:0] empty_flags();
    logic [NFLAGS-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = 1'b1;
    f[FLAG_PAR]  = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/adder_accum_ctrl_flag_reg.sv
// acc_flag_reg: registered copy of the adder flags for the current burst.
// STICKY_FLAGS_EN makes carry and overflow accumulate across the burst.
module acc_flag_reg
  import adder_accum_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_empty,
  input  logic              capture,
  input  logic [NFLAGS-1:0] add_flags,
  output logic [NFLAGS-1:0] flags
);

  logic [NFLAGS-1:0] next_flags;

  always_comb begin
    next_flags = add_flags;
`ifdef STICKY_FLAGS_EN
    next_flags[FLAG_CARRY] = add_flags[FLAG_CARRY] | flags[FLAG_CARRY];
    next_flags[FLAG_OVF]   = add_flags[FLAG_OVF]   | flags[FLAG_OVF];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (clear) begin
      flags <= '0;
    end else if (load_empty) begin
      flags <= empty_flags();
    end else if (capture) begin
      flags <= next_flags;
    end
  end

endmodule

// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: sums a burst of operands through an external flag adder.
// Optional macro STICKY_FLAGS_EN: sticky carry/overflow across the burst.
module adder_accum_ctrl
  import adder_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_sign,
  input  logic             add_zero,
  input  logic             add_carry,
  input  logic             add_overflow,
  input  logic             add_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [4:0]       out_flags,
  output logic             busy
);

  logic [1:0]        state;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              in_hs;
  logic              out_hs;
  logic              start_empty;
  logic              start_burst;
  logic [NFLAGS-1:0] add_flags;
  logic [NFLAGS-1:0] flags;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  assign start_empty = (state == ST_IDLE) && start && (len == '0);
  assign start_burst = (state == ST_IDLE) && start && (len != '0);

  assign add_x     = acc;
  assign add_y     = in_data;
  assign out_sum   = acc;
  assign out_flags = flags;

  always_comb begin
    add_flags             = '0;
    add_flags[FLAG_SIGN]  = add_sign;
    add_flags[FLAG_ZERO]  = add_zero;
    add_flags[FLAG_CARRY] = add_carry;
    add_flags[FLAG_OVF]   = add_overflow;
    add_flags[FLAG_PAR]   = add_parity;
  end

  // The accumulator is cleared on every start so an empty burst reports 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_empty) begin
            acc   <= '0;
            state <= ST_DONE;
          end else if (start_burst) begin
            acc   <= '0;
            count <= len;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_hs) begin
            acc   <= add_z;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_hs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  acc_flag_reg u_flag_reg (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_burst),
    .load_empty (start_empty),
    .capture    (in_hs),
    .add_flags  (add_flags),
    .flags      (flags)
  );

endmodule
